sdram_arbit: RTL and testbench
==============================

# sdram_arbit

- Sits between the SDRAM sub-controllers and the SDRAM pins:
  - initialisation
  - auto-refresh
  - write burst
  - read burst
- After initialisation it grants the pin bus to one requester at a time, with fixed priority refresh > write > read.
- It muxes the granted requester's command, bank and address onto the device and drives or releases the data bus.
- It is the responder to the `*_req`/`*_en`/`*_end` handshake that every sub-controller initiates.

## Interface
- DATA_W, 16, SDRAM DQ width
- ADDR_W, 13, SDRAM address width
- BA_W, 2, bank address width
- sys_clk  in  1  controller clock, 100 MHz
- sys_rst  in  1  synchronous active-low reset
- init_end  in  1  level; init sequence complete
- init_cmd / init_ba / init_addr  in  4 / BA_W / ADDR_W  init command bus
- aref_req  in  1  refresh request, held until granted
- aref_end  in  1  one-cycle pulse, refresh sequence done
- aref_cmd / aref_ba / aref_addr  in  4 / BA_W / ADDR_W  refresh command bus
- wr_req, wr_end  in  1  write request (held) / done pulse
- wr_cmd / wr_ba / wr_addr  in  4 / BA_W / ADDR_W  write command bus
- wr_sdram_en  in  1  write sub-controller wants DQ driven
- wr_data  in  DATA_W  write data
- rd_req, rd_end  in  1  read request (held) / done pulse
- rd_cmd / rd_ba / rd_addr  in  4 / BA_W / ADDR_W  read command bus
- aref_en, wr_en, rd_en  out  1  grant levels
- rd_data  out  DATA_W  DQ sampled as input (continuous assign of sdram_dq)
- sdram_cke  out  1  clock enable
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1  command pins
- sdram_ba  out  BA_W  bank pins
- sdram_addr  out  ADDR_W  address pins
- sdram_dq  inout  DATA_W  data pins

## Operation
- Command encoding is 4 bits {cs_n, ras_n, cas_n, we_n}. NOP = 4'b0111.
- States (registered):
  - INIT: stay until init_end=1, then go to ARBIT.
  - ARBIT: if aref_req go to AREF; else if wr_req go to WRITE; else if rd_req go to READ; else stay.
  - AREF: go to ARBIT on aref_end.
  - WRITE: go to ARBIT on wr_end.
  - READ: go to ARBIT on rd_end.
  - Any illegal encoding goes to INIT.
- Grants are decoded from the state register:
  - aref_en = (state==AREF)
  - wr_en = (state==WRITE)
  - rd_en = (state==READ)
- Command mux, combinational from state:
  - INIT: init_* bus
  - AREF: aref_* bus
  - WRITE: wr_* bus
  - READ: rd_* bus
  - ARBIT: NOP, ba=all ones, addr=all ones
- sdram_dq = wr_data when state==WRITE && wr_sdram_en, else high-Z.
- sdram_cke is held constant at 1.
- Requests arriving outside ARBIT are ignored. Requesters must hold req until they see their en.
- A `*_end` pulse not matching the current state is ignored.
- Simultaneous requests in ARBIT: aref wins, then wr, then rd. Losers stay pending.
- init_end deasserting after INIT has no effect.

## Timing
- Reset (sys_rst=0 at an edge):
  - state becomes INIT.
  - All grants drop to 0 after that edge.
  - Pins then follow init_*.
  - dq is released.
  - Applies mid-grant: the active sub-controller sees en=0 on the next cycle.
- Grant latency: a request sampled in ARBIT at edge n gives en=1 after edge n.
- End latency: an `*_end` pulse sampled at edge n gives en=0 after edge n, then at least one ARBIT cycle before the next grant.
- Refresh is serviced within at most one write or read burst plus 2 cycles of aref_req rising.
- Command path latency is 0 cycles (combinational) unless the configuration macro below is defined.

## Configuration
- Macro: SDRAM_ARBIT_OUT_REG_EN.
- When defined:
  - Command pins, ba, addr, dq drive value and dq output-enable are registered in sys_clk.
  - Command path latency becomes 1 cycle.
  - Register reset values: cmd NOP, ba all ones, addr all ones, dq output-enable 0.
  - Grants remain unregistered.
  - Sub-controllers must already issue their bus one cycle earlier.
- When undefined: the purely combinational mux described above.

## Structure
- Package sdram_pkg holds:
  - the 4-bit command constants (NOP, PRECHARGE 4'b0010, AUTO_REF 4'b0001, ACTIVE, WRITE, READ, LOAD_MODE)
  - the arbiter state encodings
  - the default DATA_W/ADDR_W/BA_W values
- One sub-module, sdram_cmd_reg: the optional pin output register stage. It is instantiated only under SDRAM_ARBIT_OUT_REG_EN.

## Test plan
- Reset, init_end=0, init_cmd=4'b0010, init_addr=13'h0400:
  - pins show 0010 / 0400
  - all grants 0
  - dq high-Z
  - init_end=1 gives ARBIT and pins show NOP / 1fff
- In ARBIT, aref_req, wr_req and rd_req all rise together:
  - aref_en=1 next cycle
  - after aref_end: one ARBIT cycle, then wr_en
  - after wr_end: rd_en
- WRITE granted, wr_sdram_en=1, wr_data=16'hA5A5: sdram_dq=16'hA5A5. With wr_sdram_en=0: high-Z.
- rd_en active, aref_req rises: rd_en holds until rd_end, then aref_en follows before any pending wr_req.
- sys_rst=0 for one cycle during WRITE: all grants 0 and state INIT next cycle; a stray wr_end afterwards is ignored.
- With SDRAM_ARBIT_OUT_REG_EN defined: repeat the first scenario and check that pins lag state by exactly 1 cycle and reset to NOP / 2'b11 / 13'h1fff.

Source files
------------

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM pin arbiter.
//   - 4-bit SDRAM commands, encoded {cs_n, ras_n, cas_n, we_n}
//   - arbiter state encoding
//   - default bus widths (DQ, address, bank)
package sdram_pkg;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefAddrW = 13;
    localparam int unsigned DefBaW   = 2;

    localparam logic [3:0] CmdNop       = 4'b0111;
    localparam logic [3:0] CmdPrecharge = 4'b0010;
    localparam logic [3:0] CmdAutoRef   = 4'b0001;
    localparam logic [3:0] CmdActive    = 4'b0011;
    localparam logic [3:0] CmdWrite     = 4'b0100;
    localparam logic [3:0] CmdRead      = 4'b0101;
    localparam logic [3:0] CmdLoadMode  = 4'b0000;

    typedef enum logic [2:0] {
        StInit  = 3'd0,
        StArbit = 3'd1,
        StAref  = 3'd2,
        StWrite = 3'd3,
        StRead  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sdram_cmd_reg.sv
// sdram_cmd_reg: optional pin output register stage for sdram_arbit.
// Registers command, bank, address, DQ drive value and DQ output enable,
// adding one cycle of latency. Used only when SDRAM_ARBIT_OUT_REG_EN is defined.
// Ports:
//   sys_clk, sys_rst          clock, synchronous active-low reset
//   cmd, ba, addr             muxed command bus from the arbiter
//   dq_data, dq_oe            muxed DQ drive value and output enable
//   pin_cmd, pin_ba, pin_addr registered command bus (reset: NOP, all ones)
//   pin_dq_data, pin_dq_oe    registered DQ drive value / enable (reset: released)
module sdram_cmd_reg
    import sdram_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned BA_W   = DefBaW
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [3:0]        cmd,
    input  logic [BA_W-1:0]   ba,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dq_data,
    input  logic              dq_oe,
    output logic [3:0]        pin_cmd,
    output logic [BA_W-1:0]   pin_ba,
    output logic [ADDR_W-1:0] pin_addr,
    output logic [DATA_W-1:0] pin_dq_data,
    output logic              pin_dq_oe
);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            pin_cmd     <= CmdNop;
            pin_ba      <= '1;
            pin_addr    <= '1;
            pin_dq_data <= '0;
            pin_dq_oe   <= 1'b0;
        end else begin
            pin_cmd     <= cmd;
            pin_ba      <= ba;
            pin_addr    <= addr;
            pin_dq_data <= dq_data;
            pin_dq_oe   <= dq_oe;
        end
    end

endmodule

// File: rtl/sdram_arbit.sv
// sdram_arbit: grants the SDRAM pin bus to init, auto-refresh, write or read
// sub-controllers (fixed priority refresh > write > read after init) and muxes
// the granted command bus onto the pins.
// Configuration macro: SDRAM_ARBIT_OUT_REG_EN registers the pin outputs
// (command, ba, addr, DQ value and enable) for one cycle of latency.
// Ports:
//   sys_clk, sys_rst                 clock, synchronous active-low reset
//   init_end, init_cmd/ba/addr       init done level and init command bus
//   aref_req/end, aref_cmd/ba/addr   refresh request, done pulse, command bus
//   wr_req/end, wr_cmd/ba/addr       write request, done pulse, command bus
//   wr_sdram_en, wr_data             write DQ drive request and data
//   rd_req/end, rd_cmd/ba/addr       read request, done pulse, command bus
//   aref_en, wr_en, rd_en            grant levels
//   rd_data                          DQ as seen on the pins
//   sdram_*                          SDRAM device pins
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned BA_W   = DefBaW
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DATA_W-1:0] sdram_dq
);

    arb_state_t state;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state <= StInit;
        end else begin
            unique case (state)
                StInit:  if (init_end) state <= StArbit;
                StArbit: begin
                    if (aref_req)     state <= StAref;
                    else if (wr_req)  state <= StWrite;
                    else if (rd_req)  state <= StRead;
                end
                StAref:  if (aref_end) state <= StArbit;
                StWrite: if (wr_end)   state <= StArbit;
                StRead:  if (rd_end)   state <= StArbit;
                default: state <= StInit;
            endcase
        end
    end

    assign aref_en = (state == StAref);
    assign wr_en   = (state == StWrite);
    assign rd_en   = (state == StRead);

    logic [3:0]        mux_cmd;
    logic [BA_W-1:0]   mux_ba;
    logic [ADDR_W-1:0] mux_addr;
    logic              mux_dq_oe;

    always_comb begin
        mux_cmd  = CmdNop;
        mux_ba   = '1;
        mux_addr = '1;
        unique case (state)
            StInit: begin
                mux_cmd  = init_cmd;
                mux_ba   = init_ba;
                mux_addr = init_addr;
            end
            StAref: begin
                mux_cmd  = aref_cmd;
                mux_ba   = aref_ba;
                mux_addr = aref_addr;
            end
            StWrite: begin
                mux_cmd  = wr_cmd;
                mux_ba   = wr_ba;
                mux_addr = wr_addr;
            end
            StRead: begin
                mux_cmd  = rd_cmd;
                mux_ba   = rd_ba;
                mux_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign mux_dq_oe = (state == StWrite) && wr_sdram_en;

    logic [3:0]        pin_cmd;
    logic [BA_W-1:0]   pin_ba;
    logic [ADDR_W-1:0] pin_addr;
    logic [DATA_W-1:0] pin_dq_data;
    logic              pin_dq_oe;

`ifdef SDRAM_ARBIT_OUT_REG_EN
    // Grants stay combinational; only the pin side is delayed.
    sdram_cmd_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BA_W   (BA_W)
    ) u_cmd_reg (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .cmd         (mux_cmd),
        .ba          (mux_ba),
        .addr        (mux_addr),
        .dq_data     (wr_data),
        .dq_oe       (mux_dq_oe),
        .pin_cmd     (pin_cmd),
        .pin_ba      (pin_ba),
        .pin_addr    (pin_addr),
        .pin_dq_data (pin_dq_data),
        .pin_dq_oe   (pin_dq_oe)
    );
`else
    assign pin_cmd     = mux_cmd;
    assign pin_ba      = mux_ba;
    assign pin_addr    = mux_addr;
    assign pin_dq_data = wr_data;
    assign pin_dq_oe   = mux_dq_oe;
`endif

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pin_cmd;
    assign sdram_ba   = pin_ba;
    assign sdram_addr = pin_addr;
    assign sdram_cke  = 1'b1;
    assign sdram_dq   = pin_dq_oe ? pin_dq_data : {DATA_W{1'bz}};
    assign rd_data    = sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed vector table for the arbitration scenarios, a short
// hand sequence for DQ drive/release, then randomized cycles against a
// behavioural model (owner index + initialised flag).
module tb_sdram_arbit;
    import sdram_pkg::*;

    localparam int DW = 16;
    localparam int AW = 13;
    localparam int BW = 2;

    typedef struct packed {
        logic [3:0]    cmd;
        logic [BW-1:0] ba;
        logic [AW-1:0] addr;
    } pins_t;

    typedef struct {
        logic       rst, ie, ar, ae, wq, we, rq, re;
        logic [2:0] en;    // {aref_en, wr_en, rd_en}
        pins_t      p;     // pins with the combinational command path
    } row_t;

    localparam pins_t INIT_P = '{cmd: 4'b0010, ba: 2'b00, addr: 13'h0400};
    localparam pins_t NOP_P  = '{cmd: 4'b0111, ba: 2'b11, addr: 13'h1fff};
    localparam pins_t AREF_P = '{cmd: 4'b0001, ba: 2'b10, addr: 13'h0aaa};
    localparam pins_t WR_P   = '{cmd: 4'b0100, ba: 2'b01, addr: 13'h0123};
    localparam pins_t RD_P   = '{cmd: 4'b0101, ba: 2'b10, addr: 13'h0456};

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
    logic [3:0]    init_cmd, aref_cmd, wr_cmd, rd_cmd;
    logic [BW-1:0] init_ba, aref_ba, wr_ba, rd_ba;
    logic [AW-1:0] init_addr, aref_addr, wr_addr, rd_addr;
    logic          wr_sdram_en;
    logic [DW-1:0] wr_data;
    logic          aref_en, wr_en, rd_en;
    logic [DW-1:0] rd_data;
    logic          sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [BW-1:0] sdram_ba;
    logic [AW-1:0] sdram_addr;
    wire  [DW-1:0] sdram_dq;
    logic          drv_en;
    logic [DW-1:0] drv_val;

    // Stands in for the device driving DQ while the arbiter has released it.
    assign sdram_dq = drv_en ? drv_val : {DW{1'bz}};

    always #5 sys_clk = ~sys_clk;

    sdram_arbit dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .init_end    (init_end),
        .init_cmd    (init_cmd),
        .init_ba     (init_ba),
        .init_addr   (init_addr),
        .aref_req    (aref_req),
        .aref_end    (aref_end),
        .aref_cmd    (aref_cmd),
        .aref_ba     (aref_ba),
        .aref_addr   (aref_addr),
        .wr_req      (wr_req),
        .wr_end      (wr_end),
        .wr_cmd      (wr_cmd),
        .wr_ba       (wr_ba),
        .wr_addr     (wr_addr),
        .wr_sdram_en (wr_sdram_en),
        .wr_data     (wr_data),
        .rd_req      (rd_req),
        .rd_end      (rd_end),
        .rd_cmd      (rd_cmd),
        .rd_ba       (rd_ba),
        .rd_addr     (rd_addr),
        .aref_en     (aref_en),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .sdram_cke   (sdram_cke),
        .sdram_cs_n  (sdram_cs_n),
        .sdram_ras_n (sdram_ras_n),
        .sdram_cas_n (sdram_cas_n),
        .sdram_we_n  (sdram_we_n),
        .sdram_ba    (sdram_ba),
        .sdram_addr  (sdram_addr),
        .sdram_dq    (sdram_dq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, required %h", name, $time, act, exp);
        end
    endtask

    function automatic pins_t act_pins();
        act_pins = '{cmd: {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n},
                     ba: sdram_ba, addr: sdram_addr};
    endfunction

    // Behavioural model: has init completed, and who owns the bus (-1 = nobody).
    bit m_inited = 1'b0;
    int m_owner  = -1;

    function automatic pins_t model_pins(bit inited, int owner);
        if (!inited) return '{cmd: init_cmd, ba: init_ba, addr: init_addr};
        case (owner)
            0:       return '{cmd: aref_cmd, ba: aref_ba, addr: aref_addr};
            1:       return '{cmd: wr_cmd, ba: wr_ba, addr: wr_addr};
            2:       return '{cmd: rd_cmd, ba: rd_ba, addr: rd_addr};
            default: return NOP_P;
        endcase
    endfunction

    function automatic logic [2:0] model_grant(bit inited, int owner);
        if (!inited || owner < 0) return 3'b000;
        return 3'b100 >> owner;
    endfunction

    task automatic model_step();
        if (!sys_rst) begin
            m_inited = 1'b0;
            m_owner  = -1;
        end else if (!m_inited) begin
            m_inited = init_end;
        end else if (m_owner < 0) begin
            if (aref_req)      m_owner = 0;
            else if (wr_req)   m_owner = 1;
            else if (rd_req)   m_owner = 2;
        end else if ((m_owner == 0 && aref_end) || (m_owner == 1 && wr_end) ||
                     (m_owner == 2 && rd_end)) begin
            m_owner = -1;
        end
    endtask

    task automatic set_const_bus();
        init_cmd = INIT_P.cmd; init_ba = INIT_P.ba; init_addr = INIT_P.addr;
        aref_cmd = AREF_P.cmd; aref_ba = AREF_P.ba; aref_addr = AREF_P.addr;
        wr_cmd   = WR_P.cmd;   wr_ba   = WR_P.ba;   wr_addr   = WR_P.addr;
        rd_cmd   = RD_P.cmd;   rd_ba   = RD_P.ba;   rd_addr   = RD_P.addr;
    endtask

    task automatic randomize_inputs();
        sys_rst     = ($urandom_range(0, 39) != 0);
        init_end    = ($urandom_range(0, 7) != 0);
        aref_req    = ($urandom_range(0, 3) == 0);
        wr_req      = ($urandom_range(0, 1) == 0);
        rd_req      = ($urandom_range(0, 1) == 0);
        aref_end    = ($urandom_range(0, 3) == 0);
        wr_end      = ($urandom_range(0, 3) == 0);
        rd_end      = ($urandom_range(0, 3) == 0);
        init_cmd    = 4'($urandom); init_ba = 2'($urandom); init_addr = 13'($urandom);
        aref_cmd    = 4'($urandom); aref_ba = 2'($urandom); aref_addr = 13'($urandom);
        wr_cmd      = 4'($urandom); wr_ba   = 2'($urandom); wr_addr   = 13'($urandom);
        rd_cmd      = 4'($urandom); rd_ba   = 2'($urandom); rd_addr   = 13'($urandom);
        wr_sdram_en = ($urandom_range(0, 1) == 0);
        wr_data     = 16'($urandom);
    endtask

    // One random cycle: inputs are held across the edge, then outputs compared.
    task automatic rand_cycle();
        pins_t         p_exp;
        pins_t         p_old;
        logic          oe_exp, oe_old, rst_seen;
        logic [DW-1:0] d_exp, d_old;
        p_old  = model_pins(m_inited, m_owner);
        oe_old = m_inited && (m_owner == 1) && wr_sdram_en;
        d_old  = wr_data;
        @(posedge sys_clk);
        rst_seen = sys_rst;
        model_step();
        #1;
`ifdef SDRAM_ARBIT_OUT_REG_EN
        p_exp  = rst_seen ? p_old  : NOP_P;
        oe_exp = rst_seen ? oe_old : 1'b0;
        d_exp  = d_old;
`else
        p_exp  = model_pins(m_inited, m_owner);
        oe_exp = m_inited && (m_owner == 1) && wr_sdram_en;
        d_exp  = wr_data;
`endif
        drv_en  = !oe_exp;
        drv_val = 16'($urandom);
        #1;
        chk("rand_grants", {aref_en, wr_en, rd_en}, model_grant(m_inited, m_owner));
        chk("rand_pins", act_pins(), p_exp);
        chk("rand_cke", sdram_cke, 1'b1);
        if (oe_exp) chk("rand_dq_driven", sdram_dq, d_exp);
        else        chk("rand_dq_released", rd_data, drv_val);
        randomize_inputs();
    endtask

    row_t tbl[20];

    function automatic row_t mk(input logic [7:0] in, input logic [2:0] en, input pins_t p);
        row_t r;
        {r.rst, r.ie, r.ar, r.ae, r.wq, r.we, r.rq, r.re} = in;
        r.en = en;
        r.p  = p;
        return r;
    endfunction

    initial begin
        pins_t p_req;

        //                rst ie ar ae wq we rq re
        tbl[0]  = mk(8'b0_0_0_0_0_0_0_0, 3'b000, INIT_P);
        tbl[1]  = mk(8'b1_0_0_0_0_0_0_0, 3'b000, INIT_P);
        tbl[2]  = mk(8'b1_1_0_0_0_0_0_0, 3'b000, NOP_P);
        tbl[3]  = mk(8'b1_1_1_0_1_0_1_0, 3'b100, AREF_P);  // all three at once
        tbl[4]  = mk(8'b1_1_0_0_1_0_1_0, 3'b100, AREF_P);
        tbl[5]  = mk(8'b1_1_0_1_1_0_1_0, 3'b000, NOP_P);
        tbl[6]  = mk(8'b1_1_0_0_1_0_1_0, 3'b010, WR_P);
        tbl[7]  = mk(8'b1_1_0_0_0_0_1_0, 3'b010, WR_P);
        tbl[8]  = mk(8'b1_1_0_0_0_1_1_0, 3'b000, NOP_P);
        tbl[9]  = mk(8'b1_1_0_0_0_0_1_0, 3'b001, RD_P);
        tbl[10] = mk(8'b1_1_1_0_1_0_0_0, 3'b001, RD_P);    // refresh waits for rd_end
        tbl[11] = mk(8'b1_1_1_0_1_0_0_1, 3'b000, NOP_P);
        tbl[12] = mk(8'b1_1_1_0_1_0_0_0, 3'b100, AREF_P);  // refresh before pending write
        tbl[13] = mk(8'b1_1_0_1_1_0_0_0, 3'b000, NOP_P);
        tbl[14] = mk(8'b1_1_0_0_1_0_0_0, 3'b010, WR_P);
        tbl[15] = mk(8'b0_1_0_0_1_0_0_0, 3'b000, INIT_P);  // reset mid-write
        tbl[16] = mk(8'b1_0_0_0_0_1_0_0, 3'b000, INIT_P);  // stray wr_end
        tbl[17] = mk(8'b1_1_0_0_1_1_0_0, 3'b000, NOP_P);
        tbl[18] = mk(8'b1_0_0_0_1_0_0_0, 3'b010, WR_P);    // init_end drop ignored
        tbl[19] = mk(8'b1_0_0_0_0_0_0_0, 3'b010, WR_P);

        set_const_bus();
        wr_sdram_en = 1'b0;
        wr_data     = 16'h0000;
        drv_en      = 1'b1;
        drv_val     = 16'h3c3c;

        for (int i = 0; i < 20; i++) begin
            {sys_rst, init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end} =
                {tbl[i].rst, tbl[i].ie, tbl[i].ar, tbl[i].ae,
                 tbl[i].wq, tbl[i].we, tbl[i].rq, tbl[i].re};
            @(posedge sys_clk);
            model_step();
            #2;
`ifdef SDRAM_ARBIT_OUT_REG_EN
            p_req = (!tbl[i].rst || i == 0) ? NOP_P : tbl[i-1].p;
`else
            p_req = tbl[i].p;
`endif
            chk($sformatf("tbl%0d_grants", i), {aref_en, wr_en, rd_en}, tbl[i].en);
            chk($sformatf("tbl%0d_pins", i), act_pins(), p_req);
            chk($sformatf("tbl%0d_dq_released", i), rd_data, drv_val);
        end

        // Write granted: drive DQ, then release it while still in WRITE.
        {aref_req, aref_end, wr_req, wr_end, rd_req, rd_end} = '0;
        init_end    = 1'b1;
        wr_sdram_en = 1'b1;
        wr_data     = 16'ha5a5;
        drv_en      = 1'b0;
        @(posedge sys_clk);
        model_step();
        #2;
        chk("dq_write_drive", sdram_dq, 16'ha5a5);
        chk("dq_write_grant", {aref_en, wr_en, rd_en}, 3'b010);
        wr_sdram_en = 1'b0;
        drv_en      = 1'b1;
        drv_val     = 16'h5a5a;
        @(posedge sys_clk);
        model_step();
        #2;
        chk("dq_write_release", rd_data, 16'h5a5a);

        randomize_inputs();
        for (int c = 0; c < 2000; c++) rand_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
